axi4_rd_burst_master: RTL

// Parametrised AXI4 read-only master that serves instruction-cache refills and single-word fetches.

---
 rtl/axi4_rd_burst_master_if.sv | 41 ++++
 rtl/axi4_rd_burst_master.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/axi4_rd_burst_master_if.sv
// AXI4 read-address and read-data channels between the refill master and the crossbar.
interface axi4_rd_burst_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
);
  logic [ID_W-1:0]   ARID;
  logic [ADDR_W-1:0] ARADDR;
  logic [7:0]        ARLEN;
  logic [2:0]        ARSIZE;
  logic [1:0]        ARBURST;
  logic              ARLOCK;
  logic [3:0]        ARCACHE;
  logic [2:0]        ARPROT;
  logic [3:0]        ARQOS;
  logic [3:0]        ARREGION;
  logic              ARVALID;
  logic              ARREADY;
  logic [ID_W-1:0]   RID;
  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;
  logic              RLAST;
  logic              RVALID;
  logic              RREADY;

  modport master (
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARQOS, ARREGION,
    output ARVALID,
    input  ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID,
    output RREADY
  );

  modport slave (
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARQOS, ARREGION,
    input  ARVALID,
    output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID,
    input  RREADY
  );
endinterface

// File: rtl/axi4_rd_burst_master.sv
// AXI4 read master for icache refills: one outstanding request, either a full
// cache-line INCR burst or a single beat, with cancel/drain and error flagging.
module axi4_rd_burst_master #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int ID_W       = 4,
  parameter int ARID_VAL   = 0,
  parameter int LINE_BEATS = 4
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              rd_req,
  input  logic [2:0]        rd_type,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_rdy,
  input  logic              cancel,
  output logic              ret_valid,
  output logic [DATA_W-1:0] ret_data,
  output logic              ret_last,
  output logic              ret_err,
  axi4_rd_burst_master_if.master axi
);

  localparam int                CNT_W     = $clog2(LINE_BEATS) + 1;
  localparam logic [2:0]        LINE_TYPE = 3'b100;
  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_BEATS * (DATA_W / 8) - 1);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DRAIN} state_t;

  state_t            state_q;
  logic              arvalid_q;
  logic              rready_q;
  logic              cancel_seen_q;
  logic [ADDR_W-1:0] araddr_q;
  logic [7:0]        arlen_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  last_idx;
  logic              ar_fire;
  logic              r_fire;

  logic              vld_p1;
  logic [DATA_W-1:0] ret_data_p1;
  logic              ret_last_p1;
  logic              ret_err_p1;

  // Beat counter stops at the last expected index so overlong bursts keep flagging.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                               input logic [CNT_W-1:0] lim);
    return (c == lim) ? c : c + 1'b1;
  endfunction

  assign last_idx = CNT_W'(arlen_q);
  assign ar_fire  = arvalid_q && axi.ARREADY;
  assign r_fire   = axi.RVALID && rready_q;
  assign rd_rdy   = (state_q == S_IDLE);

  assign axi.ARID     = ID_W'(ARID_VAL);
  assign axi.ARADDR   = araddr_q;
  assign axi.ARLEN    = arlen_q;
  assign axi.ARSIZE   = 3'($clog2(DATA_W / 8));
  assign axi.ARBURST  = 2'b01;
  assign axi.ARLOCK   = 1'b0;
  assign axi.ARCACHE  = 4'd0;
  assign axi.ARPROT   = 3'd0;
  assign axi.ARQOS    = 4'd0;
  assign axi.ARREGION = 4'd0;
  assign axi.ARVALID  = arvalid_q;
  assign axi.RREADY   = rready_q;

  assign ret_valid = vld_p1;
  assign ret_data  = ret_data_p1;
  assign ret_last  = ret_last_p1;
  assign ret_err   = ret_err_p1;

  // RID and the low RRESP bit carry nothing this master acts on.
  logic unused_rsp;
  assign unused_rsp = ^{axi.RID, axi.RRESP[0]};

  // Request FSM with registered AR/R handshake outputs and the one-stage return register.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q       <= S_IDLE;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      cancel_seen_q <= 1'b0;
      araddr_q      <= '0;
      arlen_q       <= '0;
      cnt_q         <= '0;
      vld_p1        <= 1'b0;
      ret_data_p1   <= '0;
      ret_last_p1   <= 1'b0;
      ret_err_p1    <= 1'b0;
    end else begin
      vld_p1 <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (rd_req && !cancel) begin
            if (rd_type == LINE_TYPE) begin
              araddr_q <= rd_addr & ~LINE_MASK;
              arlen_q  <= 8'(LINE_BEATS - 1);
            end else begin
              araddr_q <= rd_addr;
              arlen_q  <= 8'd0;
            end
            cnt_q         <= '0;
            cancel_seen_q <= 1'b0;
            arvalid_q     <= 1'b1;
            state_q       <= S_ADDR;
          end
        end
        S_ADDR: begin
          // The address is never withdrawn; a cancel only redirects the data phase.
          if (ar_fire) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= (cancel_seen_q || cancel) ? S_DRAIN : S_DATA;
          end else if (cancel) begin
            cancel_seen_q <= 1'b1;
          end
        end
        S_DATA: begin
          if (r_fire) begin
            if (cancel) begin
              // Beat on the cancel cycle is dropped; if it was the last one we are done.
              if (axi.RLAST) begin
                rready_q <= 1'b0;
                state_q  <= S_IDLE;
              end else begin
                state_q  <= S_DRAIN;
              end
            end else begin
              vld_p1      <= 1'b1;
              ret_data_p1 <= axi.RDATA;
              ret_last_p1 <= axi.RLAST;
              ret_err_p1  <= axi.RRESP[1] | (axi.RLAST != (cnt_q == last_idx));
              cnt_q       <= sat_inc(cnt_q, last_idx);
              if (axi.RLAST) begin
                rready_q <= 1'b0;
                state_q  <= S_IDLE;
              end
            end
          end else if (cancel) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (r_fire && axi.RLAST) begin
            rready_q <= 1'b0;
            state_q  <= S_IDLE;
          end
        end
        default: begin
          arvalid_q <= 1'b0;
          rready_q  <= 1'b0;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

endmodule
